// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bus bundle for uart_rx_word_packer.
// Latency: none. This file holds wiring only.
// Backpressure: none. The receiver strobes bytes and the memory takes every write.
interface uart_rx_word_packer_if #(
  parameter int ADDR_W = 14
);
  // UART receiver side: one-cycle byte strobe plus its data
  logic              I_rx_done;
  logic [7:0]        I_rx_data;
  // Memory write side: one-cycle write strobe plus address and word
  logic              O_wr_en;
  logic [ADDR_W-1:0] O_wr_addr;
  logic [31:0]       O_wr_data;

  // The packer takes bytes and drives the memory write port
  modport master (
    input  I_rx_done, I_rx_data,
    output O_wr_en, O_wr_addr, O_wr_data
  );

  // The environment drives bytes and observes writes
  modport slave (
    output I_rx_done, I_rx_data,
    input  O_wr_en, O_wr_addr, O_wr_data
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes little-endian into 32-bit words. It writes them to sequential word addresses and ends a load on an idle timeout.
// Latency: a write strobe follows the 4th byte by 1 cycle. A flush write follows the timeout by 1 cycle.
// Backpressure: none. A byte is taken on every I_rx_done in COLLECT, and the memory must accept every O_wr_en.
module uart_rx_word_packer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_W         = 14
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_en,
  uart_rx_word_packer_if.master bus,
  output logic [ADDR_W:0]       O_word_cnt,
  output logic                  O_busy,
  output logic                  O_done,
  output logic                  O_overflow
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0] CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FLUSH, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic              have_byte_q;   // timer only runs once this load has seen a byte
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic              overflow_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              start_load;
  logic              take_byte;
  logic              commit;        // a word (full or flushed partial) is written next cycle
  logic [31:0]       commit_data;

  // State register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control decode. Abort on I_en=0 takes priority over a byte or a timeout.
  always_comb begin
    state_d     = state_q;
    start_load  = 1'b0;
    take_byte   = 1'b0;
    commit      = 1'b0;
    commit_data = word_q;
    case (state_q)
      ST_IDLE: begin
        if (I_en) begin
          state_d    = ST_COLLECT;
          start_load = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (!I_en) begin
          state_d = ST_IDLE;
        end else if (bus.I_rx_done) begin
          take_byte = 1'b1;
          if (byte_idx_q == 2'd3) begin
            commit      = 1'b1;
            commit_data = {bus.I_rx_data, word_q[23:0]};
          end
        end else if (have_byte_q && (timer_q == TIMER_LAST)) begin
          if (byte_idx_q != 2'd0) begin
            commit  = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FLUSH: state_d = I_en ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!I_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: byte packing, idle timer, address/count bookkeeping and the registered write port
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      byte_idx_q  <= '0;
      word_q      <= '0;
      have_byte_q <= 1'b0;
      timer_q     <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= commit;
      if (start_load) begin
        byte_idx_q  <= '0;
        word_q      <= '0;
        have_byte_q <= 1'b0;
        timer_q     <= '0;
        addr_q      <= '0;
        word_cnt_q  <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (take_byte) begin
          byte_idx_q  <= byte_idx_q + 2'd1;
          have_byte_q <= 1'b1;
          timer_q     <= '0;
          // The word buffer is zeroed once a full word leaves, so a later flush pads with zeros
          if (byte_idx_q == 2'd3) word_q <= '0;
          else                    word_q[{byte_idx_q, 3'b000} +: 8] <= bus.I_rx_data;
        end else if ((state_q == ST_COLLECT) && have_byte_q && I_en) begin
          timer_q <= timer_q + 1'b1;
        end
        if (commit) begin
          wr_addr_q <= addr_q;
          wr_data_q <= commit_data;
          addr_q    <= addr_q + 1'b1;
          if (addr_q == '1)          overflow_q <= 1'b1;
          if (word_cnt_q != CNT_MAX) word_cnt_q <= word_cnt_q + 1'b1;
          if (!take_byte) begin
            byte_idx_q <= '0;
            word_q     <= '0;
          end
        end
      end
    end
  end

  assign bus.O_wr_en   = wr_en_q;
  assign bus.O_wr_addr = wr_addr_q;
  assign bus.O_wr_data = wr_data_q;
  assign O_word_cnt    = word_cnt_q;
  assign O_overflow    = overflow_q;
  assign O_busy        = (state_q == ST_COLLECT) || (state_q == ST_FLUSH);
  assign O_done        = (state_q == ST_DONE);

endmodule
